nonrestoring_divider: RTL
=========================

Name: nonrestoring_divider

Overview:
- Sequential unsigned integer divider, dividend / divisor -> quotient, remainder.
- Non-restoring algorithm: one add-or-subtract per cycle through a single shared add/sub datapath.
- Inverse arithmetic companion to the combinational ripple add/sub; sits beside it in the arithmetic library.
- Start/busy/done handshake for use under a controller FSM.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend, sampled with start
divisor  input  WIDTH  unsigned divisor, sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  registered flag, divisor was 0

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: state=IDLE.
- Reset: busy, done, div_by_zero = 0.
- Reset: quotient, remainder = 0.
- Reset: internal A, Q, M, count = 0.
- Reset mid-operation aborts immediately; no partial results are visible.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, divisor!=0:
  - Load M=divisor (zero-extended to WIDTH+1), A=0, Q=dividend, count=WIDTH.
  - Next state CALC.
- IDLE, start=1, divisor==0:
  - Next state DONE.
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
- CALC, each cycle:
  - Shift {A,Q} left 1.
  - If the old A sign bit (A[WIDTH]) = 1, A = A + M; else A = A - M.
  - Q[0] = ~A_new[WIDTH].
  - Decrement count; leave for FIX when count reaches 0. CALC lasts exactly WIDTH cycles.
- FIX, one cycle:
  - If A[WIDTH]=1, A = A + M.
  - Register quotient = Q, remainder = A[WIDTH-1:0], div_by_zero = 0.
  - Next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency, start sampled at edge 0:
  - Normal: done high in cycle WIDTH+2.
  - Divide-by-zero: done high in cycle 1.
- Output hold: quotient, remainder, div_by_zero hold until the next accepted start overwrites them in FIX/DONE. They are not cleared on start.
- start while busy: ignored. No queueing, no effect on the current operation.
- start in the DONE cycle: ignored. Accepted no earlier than the IDLE cycle after.
- Operand changes after acceptance: no effect; operands are captured.
- Arithmetic: A is WIDTH+1 bits two's complement; M is never negative.
  - Subtraction = add with ~M and carry-in 1, matching the add/sub convention: sub input drives the b-inversion and the carry-in.
  - Final carry-out is discarded; the sign comes from bit WIDTH.
- Invariants for every divisor!=0: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, FIX, DONE}
  - localparam DIV_W_DEFAULT = 4
- Sub-module addsub_n:
  - Parameterised N-bit ripple add/sub; ports sub, a, b, sum, ca; b XOR sub per bit, carry-in = sub.
  - Instantiated once at N = WIDTH+1, shared by CALC and FIX.
  - Divider drives sub = ~A[WIDTH] in CALC, sub = 0 in FIX.

Test Plan:
- 13/3, WIDTH=4 -> quotient=4, remainder=1, div_by_zero=0; done exactly 6 cycles after start edge, single-cycle pulse; busy high cycles 1..6.
- 15/1 -> q=15, r=0.
- 5/7 -> q=0, r=5.
- 0/9 -> q=0, r=0.
- 15/15 -> q=1, r=0.
- 9/0 -> div_by_zero=1, quotient=4'hF, remainder=9; done in cycle 1; the next op 8/2 -> q=4, r=0, div_by_zero=0.
- 12/5 started, then start with 7/1 pulsed at cycle 3 -> ignored, result q=2, r=2. Outputs hold until the next start: 12/4 -> q=3, r=0.
- Reset mid-operation: rst_n low asynchronously at cycle 3 of 14/3 -> all outputs 0 immediately, no done. After release, 14/3 -> q=4, r=2.
- Exhaustive sweep: all 256 (dividend, divisor) pairs back-to-back against a behavioural model (/, %; 0-divisor rule) -> zero mismatches, every op done at WIDTH+2 (or 1 for zero divisor).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int unsigned DIV_W_DEFAULT = 4;

endpackage : div_pkg

// File: rtl/addsub_n.sv
// N-bit ripple add/sub: sum = a + (b ^ {N{sub}}) + sub, carry-out on ca.
module addsub_n #(
  parameter int unsigned N = 5
) (
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ca
);

  logic [N:0]   carry;
  logic [N-1:0] b_eff;

  // Ripple chain; sub inverts b and supplies the carry-in to form two's-complement subtraction.
  always_comb begin
    carry    = '0;
    sum      = '0;
    b_eff    = b ^ {N{sub}};
    carry[0] = sub;
    for (int i = 0; i < int'(N); i++) begin
      sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
    ca = carry[N];
  end

endmodule : addsub_n

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned divider: one non-restoring add/sub step per cycle, start/busy/done handshake.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [AW-1:0]    a_reg;
  logic [AW-1:0]    m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    count;

  logic [AW-1:0]    op_a;
  logic             op_sub;
  logic [AW-1:0]    sum;
  logic             unused_carry;

  // Operand select for the shared add/sub: shifted partial remainder in CALC, plain A in FIX.
  always_comb begin
    op_a   = a_reg;
    op_sub = 1'b0;
    if (state == CALC) begin
      op_a   = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      op_sub = ~a_reg[WIDTH];
    end
  end

  addsub_n #(
    .N (AW)
  ) u_addsub (
    .sub (op_sub),
    .a   (op_a),
    .b   (m_reg),
    .sum (sum),
    .ca  (unused_carry)
  );

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              m_reg <= {1'b0, divisor};
              a_reg <= '0;
              q_reg <= dividend;
              count <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          a_reg <= sum;
          q_reg <= {q_reg[WIDTH-2:0], ~sum[WIDTH]};
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A negative final partial remainder gets M added back once.
          if (a_reg[WIDTH]) begin
            a_reg     <= sum;
            remainder <= sum[WIDTH-1:0];
          end else begin
            remainder <= a_reg[WIDTH-1:0];
          end
          quotient    <= q_reg;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : nonrestoring_divider
